oric_ram_sequencer: RTL and testbench

Sequencer and arbiter for the Oric 64 KiB system RAM on `clk_sys`. It owns the single RAM port and shares it between three users: the power-on/reset clear sweep, the HPS loader (ioctl download into RAM), and the `oricatmos` CPU/video bus. It replaces ad-hoc clear-counter and write-enable gating at top level with one state machine. It reports `busy`/`cpu_hold` so the core can be held while the port is taken.

---
 rtl/oric_pkg.sv | 13 +
 rtl/ram_load_buffer.sv | 44 ++++
 rtl/oric_ram_sequencer.sv | 135 +++++++++++++
 tb/tb_oric_ram_sequencer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oric_pkg.sv
// rtl/oric_pkg.sv - shared types and constants for the Oric RAM sequencer
package oric_pkg;

    localparam int         ORIC_RAM_AW   = 16;
    localparam logic [7:0] ORIC_RAM_FILL = 8'hFF;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } ram_seq_state_t;

endpackage

// File: rtl/ram_load_buffer.sv
// rtl/ram_load_buffer.sv - one-entry loader skid buffer with write ack and byte counter
module ram_load_buffer #(
    parameter int AW = 16
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          start,
    input  logic          ld_wr,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          pend,
    output logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_data,
    output logic [AW:0]   ld_count
);

    logic capture;

    assign capture = enable & ld_wr;

    // A held byte always drains on the cycle after capture, so the buffer can
    // refill in the very cycle it empties and sustains one byte per clock.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            pend     <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
            ld_count <= '0;
        end else begin
            if (capture) begin
                buf_addr <= ld_addr;
                buf_data <= ld_data;
            end
            pend <= capture;
            if (start) begin
                ld_count <= '0;
            end else if (pend) begin
                ld_count <= ld_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/oric_ram_sequencer.sv
// rtl/oric_ram_sequencer.sv - arbiter for the Oric system RAM port: clear sweep, loader, CPU
module oric_ram_sequencer
    import oric_pkg::*;
#(
    parameter int         AW   = ORIC_RAM_AW,
    parameter logic [7:0] FILL = ORIC_RAM_FILL
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          clear_req,
    input  logic [AW-1:0] cpu_ad,
    input  logic [7:0]    cpu_d,
    input  logic          cpu_we,
    input  logic          cpu_cs,
    output logic [7:0]    cpu_q,
    input  logic          ld_active,
    input  logic          ld_wr,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          ld_ack,
    output logic [AW:0]   ld_count,
    output logic [AW-1:0] ram_ad,
    output logic [7:0]    ram_d,
    output logic          ram_we,
    input  logic [7:0]    ram_q,
    output logic          busy,
    output logic          cpu_hold
);

    ram_seq_state_t state;
    logic [AW-1:0]  clr_addr;
    logic           clr_pend;
    logic           ld_pend;
    logic [AW-1:0]  buf_addr;
    logic [7:0]     buf_data;
    logic           load_start;
    logic           load_capture;
    logic           ram_we_mux;

    // Entry into LOAD is level-based so a session still active after a sweep is picked up.
    assign load_start   = (state == RUN) & ~clear_req & ld_active;
    assign load_capture = (state == LOAD) & ld_active;

    ram_load_buffer #(.AW(AW)) u_load_buffer (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .enable   (load_capture),
        .start    (load_start),
        .ld_wr    (ld_wr),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .pend     (ld_pend),
        .buf_addr (buf_addr),
        .buf_data (buf_data),
        .ld_count (ld_count)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
            clr_pend <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clear_req) begin
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                        if (&clr_addr) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (clear_req) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end else if (ld_active) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // A clear requested mid-session waits until the last byte has drained.
                    if (!ld_active && !ld_pend) begin
                        clr_pend <= 1'b0;
                        if (clr_pend || clear_req) begin
                            state    <= CLEAR;
                            clr_addr <= '0;
                        end else begin
                            state <= RUN;
                        end
                    end else if (clear_req) begin
                        clr_pend <= 1'b1;
                    end
                end
                default: begin
                    state    <= CLEAR;
                    clr_addr <= '0;
                end
            endcase
        end
    end

    always_comb begin
        ram_ad     = cpu_ad;
        ram_d      = cpu_d;
        ram_we_mux = 1'b0;
        case (state)
            CLEAR: begin
                ram_ad     = clr_addr;
                ram_d      = FILL;
                ram_we_mux = 1'b1;
            end
            RUN: begin
                ram_we_mux = cpu_we & cpu_cs;
            end
            LOAD: begin
                if (ld_pend) begin
                    ram_ad     = buf_addr;
                    ram_d      = buf_data;
                    ram_we_mux = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ram_we   = ram_we_mux & reset_n;
    assign ld_ack   = ld_pend & reset_n;
    assign busy     = (state != RUN) | ~reset_n;
    assign cpu_hold = busy;
    assign cpu_q    = ram_q;

endmodule

// File: tb/tb_oric_ram_sequencer.sv
// tb/tb_oric_ram_sequencer.sv - randomized self-checking bench for oric_ram_sequencer
module tb_oric_ram_sequencer;

    localparam int AW    = 13;
    localparam int DEPTH = 1 << AW;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          clear_req;
    logic [AW-1:0] cpu_ad;
    logic [7:0]    cpu_d;
    logic          cpu_we;
    logic          cpu_cs;
    logic [7:0]    cpu_q;
    logic          ld_active;
    logic          ld_wr;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          ld_ack;
    logic [AW:0]   ld_count;
    logic [AW-1:0] ram_ad;
    logic [7:0]    ram_d;
    logic          ram_we;
    logic [7:0]    ram_q;
    logic          busy;
    logic          cpu_hold;

    logic [7:0] mem     [DEPTH];
    logic [7:0] exp_mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_sys = ~clk_sys;

    oric_ram_sequencer #(.AW(AW), .FILL(8'hFF)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .clear_req (clear_req),
        .cpu_ad    (cpu_ad),
        .cpu_d     (cpu_d),
        .cpu_we    (cpu_we),
        .cpu_cs    (cpu_cs),
        .cpu_q     (cpu_q),
        .ld_active (ld_active),
        .ld_wr     (ld_wr),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ack    (ld_ack),
        .ld_count  (ld_count),
        .ram_ad    (ram_ad),
        .ram_d     (ram_d),
        .ram_we    (ram_we),
        .ram_q     (ram_q),
        .busy      (busy),
        .cpu_hold  (cpu_hold)
    );

    // Synchronous RAM with registered read data.
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_ad] <= ram_d;
        ram_q <= mem[ram_ad];
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic mem_diff(output int diffs);
        diffs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== exp_mem[i]) diffs++;
        end
    endtask

    task automatic expect_all_fill();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'hFF;
    endtask

    // Follows a sweep cycle by cycle until busy drops, counting writes and out-of-order cycles.
    task automatic sweep_observe(output int writes, output int bad);
        writes = 0;
        bad    = 0;
        for (int c = 0; c < DEPTH + 16; c++) begin
            @(negedge clk_sys);
            if (!busy) return;
            if (!(ram_we === 1'b1 && ram_ad === AW'(writes) && ram_d === 8'hFF && ld_ack === 1'b0)) bad++;
            writes++;
            step();
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        clear_req = 1'b0;
        ld_active = 1'b0;
        ld_wr     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        cpu_ad    = AW'($urandom);
        cpu_d     = 8'($urandom);
        cpu_we    = 1'b1;
        cpu_cs    = 1'b1;
        repeat (3) step();
        @(negedge clk_sys);
        n_checks++;
        if ({ram_we, ld_ack, busy, cpu_hold} !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_outputs: got we/ack/busy/hold=%b required 0011", {ram_we, ld_ack, busy, cpu_hold});
        end
        n_checks++;
        if (ld_count !== '0) begin
            n_fail++;
            $display("FAIL reset_ld_count: got %0d required 0", ld_count);
        end
        cpu_we = 1'b0;
        cpu_cs = 1'b0;
    endtask

    task automatic test_clear_sweep();
        int writes, bad, diffs;
        step();
        reset_n = 1'b1;
        sweep_observe(writes, bad);
        n_checks++;
        if (writes !== DEPTH) begin
            n_fail++;
            $display("FAIL sweep_len: got %0d writes required %0d", writes, DEPTH);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL sweep_order: got %0d bad cycles required 0", bad);
        end
        n_checks++;
        if (cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_release: got cpu_hold=%b required 0", cpu_hold);
        end
        expect_all_fill();
        mem_diff(diffs);
        n_checks++;
        if (diffs !== 0) begin
            n_fail++;
            $display("FAIL sweep_fill: got %0d differing bytes required 0", diffs);
        end
    endtask

    task automatic test_cpu_rw();
        logic [AW-1:0] a;
        logic [7:0]    d;
        for (int i = 0; i < 8; i++) begin
            a = (i == 0) ? AW'(16'h0400) : AW'($urandom_range(16'h0800, DEPTH - 1));
            d = (i == 0) ? 8'h5A : 8'($urandom);
            step();
            cpu_ad = a; cpu_d = d; cpu_we = 1'b1; cpu_cs = 1'b1;
            @(negedge clk_sys);
            n_checks++;
            if ({ram_we, ram_ad, ram_d} !== {1'b1, a, d}) begin
                n_fail++;
                $display("FAIL cpu_write: got we=%b ad=%h d=%h required we=1 ad=%h d=%h", ram_we, ram_ad, ram_d, a, d);
            end
            exp_mem[a] = d;
            step();
            cpu_we = 1'b0;
            @(negedge clk_sys);
            step();
            cpu_ad = AW'($urandom);
            @(negedge clk_sys);
            n_checks++;
            if (cpu_q !== d) begin
                n_fail++;
                $display("FAIL cpu_read: got %h required %h at %h", cpu_q, d, a);
            end
        end
        step();
        cpu_we = 1'b1; cpu_cs = 1'b0;
        @(negedge clk_sys);
        n_checks++;
        if (ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_cs_gate: got ram_we=%b required 0", ram_we);
        end
        cpu_we = 1'b0;
    endtask

    // Streams n bytes back-to-back starting at base; optionally pulses clear_req at byte clr_at.
    task automatic run_load(input int n, input logic [AW-1:0] base, input int clr_at, output int acks, output int bad);
        logic [AW+7:0] q[$];
        logic [AW+7:0] e;
        acks = 0;
        bad  = 0;
        step();
        ld_active = 1'b1;
        step();
        for (int k = 0; k <= n; k++) begin
            step();
            clear_req = (k == clr_at);
            if (k < n) begin
                ld_wr   = 1'b1;
                ld_addr = base + AW'(k);
                ld_data = 8'($urandom);
                q.push_back({ld_addr, ld_data});
                exp_mem[ld_addr] = ld_data;
            end else begin
                ld_wr     = 1'b0;
                ld_active = 1'b0;
            end
            cpu_we = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            cpu_cs = 1'b1;
            cpu_ad = AW'(16'h0700) + AW'($urandom_range(0, 255));
            cpu_d  = 8'($urandom);
            @(negedge clk_sys);
            if (k == 0) begin
                if (ld_ack !== 1'b0 || ram_we !== 1'b0) bad++;
            end else begin
                e = q.pop_front();
                if ({ld_ack, ram_we, ram_ad, ram_d} === {2'b11, e}) acks++;
                else bad++;
            end
        end
        clear_req = 1'b0;
        cpu_we    = 1'b0;
        cpu_cs    = 1'b0;
    endtask

    task automatic test_load();
        int acks, bad, diffs, lat;
        run_load(256, AW'(16'h0500), -1, acks, bad);
        n_checks++;
        if (acks !== 256 || bad !== 0) begin
            n_fail++;
            $display("FAIL load_acks: got %0d acks %0d bad cycles required 256 acks 0 bad", acks, bad);
        end
        lat = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            lat++;
            @(negedge clk_sys);
            if (!busy) break;
        end
        n_checks++;
        if (busy !== 1'b0 || lat > 2) begin
            n_fail++;
            $display("FAIL load_exit: got busy=%b after %0d cycles required 0 within 2", busy, lat);
        end
        n_checks++;
        if (ld_count !== (AW+1)'(256)) begin
            n_fail++;
            $display("FAIL load_count: got %0d required 256", ld_count);
        end
        mem_diff(diffs);
        n_checks++;
        if (diffs !== 0) begin
            n_fail++;
            $display("FAIL load_mem: got %0d differing bytes required 0", diffs);
        end
    endtask

    task automatic test_clear_defer();
        int acks, bad, diffs, writes;
        run_load(20, AW'(16'h0100), 10, acks, bad);
        n_checks++;
        if (acks !== 20 || bad !== 0) begin
            n_fail++;
            $display("FAIL defer_acks: got %0d acks %0d bad cycles required 20 acks 0 bad", acks, bad);
        end
        step();
        @(negedge clk_sys);
        n_checks++;
        if ({ram_we, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL defer_drain: got we/busy=%b required 01", {ram_we, busy});
        end
        n_checks++;
        if (ld_count !== (AW+1)'(20)) begin
            n_fail++;
            $display("FAIL defer_count: got %0d required 20", ld_count);
        end
        step();
        mem_diff(diffs);
        n_checks++;
        if (diffs !== 0) begin
            n_fail++;
            $display("FAIL defer_bytes: got %0d differing bytes required 0", diffs);
        end
        sweep_observe(writes, bad);
        n_checks++;
        if (writes !== DEPTH || bad !== 0) begin
            n_fail++;
            $display("FAIL defer_sweep: got %0d writes %0d bad required %0d writes 0 bad", writes, bad, DEPTH);
        end
        expect_all_fill();
        mem_diff(diffs);
        n_checks++;
        if (diffs !== 0) begin
            n_fail++;
            $display("FAIL defer_fill: got %0d differing bytes required 0", diffs);
        end
    endtask

    task automatic test_reset_mid_clear();
        int writes, bad, found;
        step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        found = 0;
        for (int c = 0; c < DEPTH; c++) begin
            @(negedge clk_sys);
            if (ram_ad === AW'(16'h1234)) begin
                found = 1;
                break;
            end
            step();
        end
        n_checks++;
        if (found !== 1) begin
            n_fail++;
            $display("FAIL midclr_reach: got found=%0d required 1", found);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({ram_we, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL midclr_gate: got we/busy=%b required 01", {ram_we, busy});
        end
        step();
        reset_n = 1'b1;
        sweep_observe(writes, bad);
        n_checks++;
        if (writes !== DEPTH || bad !== 0) begin
            n_fail++;
            $display("FAIL midclr_sweep: got %0d writes %0d bad required %0d writes 0 bad", writes, bad, DEPTH);
        end
    endtask

    task automatic test_reset_mid_load();
        int writes, bad;
        step();
        ld_active = 1'b1;
        step();
        ld_wr = 1'b1; ld_addr = AW'(16'h0300); ld_data = 8'h3C;
        step();
        ld_wr   = 1'b0;
        reset_n = 1'b0;
        @(negedge clk_sys);
        n_checks++;
        if ({ld_ack, ram_we} !== 2'b00) begin
            n_fail++;
            $display("FAIL midld_ack: got ack/we=%b required 00", {ld_ack, ram_we});
        end
        step();
        reset_n   = 1'b1;
        ld_active = 1'b0;
        n_checks++;
        if (ld_count !== '0) begin
            n_fail++;
            $display("FAIL midld_count: got %0d required 0", ld_count);
        end
        sweep_observe(writes, bad);
        n_checks++;
        if (writes !== DEPTH || bad !== 0) begin
            n_fail++;
            $display("FAIL midld_sweep: got %0d writes %0d bad required %0d writes 0 bad", writes, bad, DEPTH);
        end
    endtask

    task automatic test_clear_and_load();
        int writes, bad;
        step();
        clear_req = 1'b1;
        ld_active = 1'b1;
        step();
        clear_req = 1'b0;
        sweep_observe(writes, bad);
        n_checks++;
        if (writes !== DEPTH || bad !== 0) begin
            n_fail++;
            $display("FAIL both_sweep: got %0d writes %0d bad required %0d writes 0 bad", writes, bad, DEPTH);
        end
        step();
        @(negedge clk_sys);
        n_checks++;
        if ({busy, cpu_hold, ram_we} !== 3'b110) begin
            n_fail++;
            $display("FAIL both_load: got busy/hold/we=%b required 110", {busy, cpu_hold, ram_we});
        end
        ld_active = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clk_sys);
            if (!busy) break;
        end
        n_checks++;
        if (busy !== 1'b0 || ld_count !== '0) begin
            n_fail++;
            $display("FAIL both_exit: got busy=%b count=%0d required 0 and 0", busy, ld_count);
        end
    endtask

    initial begin
        test_reset();
        test_clear_sweep();
        test_cpu_rw();
        test_load();
        test_clear_defer();
        test_reset_mid_clear();
        test_reset_mid_load();
        test_clear_and_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
